// File: rtl/main_control.sv
// main_control: multicycle Moore control FSM for a MIPS-style datapath with mem_ready handshaking.
module main_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_op,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t cur, nxt;
  assign state = cur;
  always_ff @(posedge clk)
    if (rst) cur <= FETCH;
    else cur <= nxt;
  always_comb begin
    nxt = FETCH;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite} = '0;
    {ALUSrcA, ALUSrcB, ALU_op, PCSource, illegal_op} = '0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R: nxt = EXEC;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ: nxt = BRANCH;
          OP_J: nxt = JUMP;
          OP_ADDI: nxt = ADDIEX;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        nxt = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALU_op = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALU_op = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
      default: nxt = FETCH;
    endcase
    if (rst) begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite} = '0;
      {ALUSrcA, ALUSrcB, ALU_op, PCSource, illegal_op} = '0;
    end
  end
endmodule

// File: doc/main_control.md
MAIN_CONTROL -- requirements
Module: main_control

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clk and rst; rst sampled on rising clk only.
REQ-002 SHALL have no parameters.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 opcode  in  6  instruction[31:26], valid from DECODE onward (IR held externally).
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 PCWrite  out  1  unconditional PC load.
REQ-008 PCWriteCond  out  1  PC load if ALU zero.
REQ-009 IorD  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 MemRead  out  1  memory read request.
REQ-011 MemWrite  out  1  memory write request.
REQ-012 IRWrite  out  1  instruction register load.
REQ-013 MemtoReg  out  1  writeback data: 0=ALUOut, 1=MDR.
REQ-014 RegDst  out  1  write register: 0=rt, 1=rd.
REQ-015 RegWrite  out  1  register file write enable.
REQ-016 ALUSrcA  out  1  ALU A: 0=PC, 1=rs.
REQ-017 ALUSrcB  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-018 ALU_op  out  2  to ALU_control: 00=add, 01=sub, 10=use funct; 11 never driven.
REQ-019 illegal_op  out  1  one-cycle pulse on unsupported opcode.
REQ-020 state  out  4  current state encoding (debug/verification).

Function
REQ-021 SHALL be a multicycle Moore FSM, state register updated on rising clk; outputs decoded from state only, except IRWrite/PCWrite in FETCH (also gated by mem_ready).
REQ-022 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-023 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=00, PCSource=00, IRWrite=PCWrite=mem_ready; stays in FETCH while mem_ready=0, else -> DECODE.
REQ-024 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=00; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->FETCH with illegal_op=1 this cycle.
REQ-025 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=00; opcode 100011->MEMRD, 101011->MEMWR.
REQ-026 MEMRD: MemRead=1, IorD=1; holds until mem_ready=1, then -> MEMWB.
REQ-027 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-028 MEMWR: MemWrite=1, IorD=1; holds until mem_ready=1, then -> FETCH.
REQ-029 EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=10; -> ALUWB.
REQ-030 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_op=01, PCWriteCond=1, PCSource=01; -> FETCH.
REQ-032 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-033 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_op=00; -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
REQ-034 Every output not listed for a state SHALL be 0; MemRead and MemWrite never both 1.
REQ-035 Unused encodings 12-15 SHALL drive all outputs 0 and go to FETCH next cycle.
REQ-036 Cycle counts with mem_ready=1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.

Reset
REQ-037 rst=1 at a rising edge SHALL load state=FETCH regardless of current state, including mid-instruction or mid-wait.
REQ-038 While rst=1 all control outputs and illegal_op SHALL be forced 0 (state shows its current value); rst overrides mem_ready.

Verification
REQ-039 rst held 2 cycles from EXEC -> state=0 after the first edge, all outputs 0 while rst=1; after release, MemRead=1.
REQ-040 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-041 sw (101011), mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then FETCH.
REQ-042 R-type (000000) -> ALU_op 00,00,10,xx; RegDst=1 and RegWrite=1 in ALUWB only.
REQ-043 beq (000100) -> ALU_op=01, PCWriteCond=1, PCSource=01 in state 8; j (000010) -> PCWrite=1, PCSource=10 in state 9.
REQ-044 opcode 111111 in DECODE -> illegal_op=1 for exactly one cycle, next state=0; mem_ready=0 in FETCH -> IRWrite=PCWrite=0, state stays 0.
